// File: rtl/pio_delay_sideset.sv
// PIO execution-stage helper: applies side-set pins/pindirs once per instruction
// and runs the post-instruction delay counter that holds off the next issue.
module pio_delay_sideset #(
    parameter int unsigned PINS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            restart,
    input  logic            exec_valid,
    input  logic            instr_stall,
    input  logic [4:0]      delay,
    input  logic [4:0]      side_set,
    input  logic            sideset_enabled,
    input  logic [2:0]      sideset_count,
    input  logic [4:0]      sideset_base,
    input  logic            sideset_pindir,
    output logic            busy,
    output logic [4:0]      delay_cnt,
    output logic [PINS-1:0] pin_out,
    output logic [PINS-1:0] pin_mask,
    output logic [PINS-1:0] dir_out,
    output logic [PINS-1:0] dir_mask
);

    localparam int unsigned IDX_W   = (PINS > 1) ? $clog2(PINS) : 1;
    localparam int unsigned SS_BITS = 5;

    logic [4:0]      delay_cnt_q, delay_cnt_d;
    logic            busy_q, busy_d;
    logic            applied_q, applied_d;
    logic [PINS-1:0] pin_out_q, pin_out_d;
    logic [PINS-1:0] pin_mask_q, pin_mask_d;
    logic [PINS-1:0] dir_out_q, dir_out_d;
    logic [PINS-1:0] dir_mask_q, dir_mask_d;
    logic            issue_c;
    logic            fire_c;
    logic [IDX_W-1:0] lane;

    always_comb begin
        delay_cnt_d = delay_cnt_q;
        applied_d   = applied_q;
        pin_out_d   = pin_out_q;
        dir_out_d   = dir_out_q;
        pin_mask_d  = '0;
        dir_mask_d  = '0;
        lane        = '0;

        issue_c = exec_valid & en & ~busy_q & ~restart;
        fire_c  = issue_c & sideset_enabled & (sideset_count != 3'd0) & ~applied_q;

        if (restart) begin
            delay_cnt_d = 5'd0;
            applied_d   = 1'b0;
        end else if (en) begin
            if (issue_c) begin
                // applied tracks "side-set already done for this stalled instruction"
                applied_d = instr_stall;
                if (!instr_stall && (delay != 5'd0)) begin
                    delay_cnt_d = delay;
                end
            end else if (delay_cnt_q != 5'd0) begin
                delay_cnt_d = delay_cnt_q - 5'd1;
            end

            if (fire_c) begin
                for (int i = 0; i < int'(SS_BITS); i++) begin
                    if (i < int'(sideset_count)) begin
                        lane = IDX_W'((32'(sideset_base) + 32'(i)) % PINS);
                        if (sideset_pindir) begin
                            dir_out_d[lane]  = side_set[3'(i)];
                            dir_mask_d[lane] = 1'b1;
                        end else begin
                            pin_out_d[lane]  = side_set[3'(i)];
                            pin_mask_d[lane] = 1'b1;
                        end
                    end
                end
            end
        end

        busy_d = (delay_cnt_d != 5'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay_cnt_q <= 5'd0;
            busy_q      <= 1'b0;
            applied_q   <= 1'b0;
            pin_out_q   <= '0;
            pin_mask_q  <= '0;
            dir_out_q   <= '0;
            dir_mask_q  <= '0;
        end else begin
            delay_cnt_q <= delay_cnt_d;
            busy_q      <= busy_d;
            applied_q   <= applied_d;
            pin_out_q   <= pin_out_d;
            pin_mask_q  <= pin_mask_d;
            dir_out_q   <= dir_out_d;
            dir_mask_q  <= dir_mask_d;
        end
    end

    assign busy      = busy_q;
    assign delay_cnt = delay_cnt_q;
    assign pin_out   = pin_out_q;
    assign pin_mask  = pin_mask_q;
    assign dir_out   = dir_out_q;
    assign dir_mask  = dir_mask_q;

endmodule

// File: tb/tb_pio_delay_sideset.sv
// Self-checking bench for pio_delay_sideset: directed scenarios plus a
// randomized run against a cycle-level behavioural reference model.
module tb_pio_delay_sideset;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        restart;
    logic        exec_valid;
    logic        instr_stall;
    logic [4:0]  delay;
    logic [4:0]  side_set;
    logic        sideset_enabled;
    logic [2:0]  sideset_count;
    logic [4:0]  sideset_base;
    logic        sideset_pindir;
    logic        busy;
    logic [4:0]  delay_cnt;
    logic [31:0] pin_out;
    logic [31:0] pin_mask;
    logic [31:0] dir_out;
    logic [31:0] dir_mask;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_cnt;
    bit          m_applied;
    logic [31:0] m_pin_out, m_pin_mask, m_dir_out, m_dir_mask;

    pio_delay_sideset #(.PINS(32)) dut (
        .clk(clk), .reset(reset), .en(en), .restart(restart),
        .exec_valid(exec_valid), .instr_stall(instr_stall), .delay(delay),
        .side_set(side_set), .sideset_enabled(sideset_enabled),
        .sideset_count(sideset_count), .sideset_base(sideset_base),
        .sideset_pindir(sideset_pindir), .busy(busy), .delay_cnt(delay_cnt),
        .pin_out(pin_out), .pin_mask(pin_mask), .dir_out(dir_out), .dir_mask(dir_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; restart = 1'b0; exec_valid = 1'b0; instr_stall = 1'b0;
        delay = 5'd0; side_set = 5'd0; sideset_enabled = 1'b0;
        sideset_count = 3'd0; sideset_base = 5'd0; sideset_pindir = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit issue;
        int nbits;
        int lane;
        m_pin_mask = '0;
        m_dir_mask = '0;
        issue = exec_valid && en && (m_cnt == 0) && !restart;
        if (restart) begin
            m_cnt = 0;
            m_applied = 0;
        end else if (en) begin
            if (issue && sideset_enabled && sideset_count != 0 && !m_applied) begin
                nbits = (sideset_count > 5) ? 5 : int'(sideset_count);
                for (int i = 0; i < nbits; i++) begin
                    lane = (int'(sideset_base) + i) % 32;
                    if (sideset_pindir) begin
                        m_dir_out[lane] = side_set[i];
                        m_dir_mask[lane] = 1'b1;
                    end else begin
                        m_pin_out[lane] = side_set[i];
                        m_pin_mask[lane] = 1'b1;
                    end
                end
            end
            if (issue) begin
                m_applied = instr_stall;
                if (!instr_stall) m_cnt = int'(delay);
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
        n_checks++; if (delay_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", delay_cnt); end
        n_checks++; if (pin_out !== 32'd0) begin n_fail++; $display("FAIL reset_pin_out got %h exp 0", pin_out); end
        n_checks++; if (pin_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pin_mask got %h exp 0", pin_mask); end
        n_checks++; if (dir_out !== 32'd0) begin n_fail++; $display("FAIL reset_dir_out got %h exp 0", dir_out); end
        n_checks++; if (dir_mask !== 32'd0) begin n_fail++; $display("FAIL reset_dir_mask got %h exp 0", dir_mask); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        idle_inputs();
        exec_valid = 1; delay = 5'd3; side_set = 5'b00101; sideset_enabled = 1;
        sideset_count = 3'd3; sideset_base = 5'd4;
        tick();
        exec_valid = 0;
        n_checks++; if (pin_mask !== 32'h70) begin n_fail++; $display("FAIL basic_mask got %h exp 70", pin_mask); end
        n_checks++; if ((pin_out & 32'h70) !== 32'h50) begin n_fail++; $display("FAIL basic_pins got %h exp 50", pin_out & 32'h70); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy1 got %0b exp 1", busy); end
        n_checks++; if (delay_cnt !== 5'd3) begin n_fail++; $display("FAIL basic_cnt got %0d exp 3", delay_cnt); end
        tick();
        n_checks++; if (pin_mask !== 32'h0) begin n_fail++; $display("FAIL basic_strobe_len got %h exp 0", pin_mask); end
        tick();
        n_checks++; if (busy !== 1'b1 || delay_cnt !== 5'd1) begin n_fail++; $display("FAIL basic_tn got busy=%0b cnt=%0d exp 1/1", busy, delay_cnt); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got %0b exp 0", busy); end
    endtask

    task automatic test_wrap();
        idle_inputs();
        exec_valid = 1; side_set = 5'b01011; sideset_enabled = 1;
        sideset_count = 3'd4; sideset_base = 5'd30;
        tick();
        exec_valid = 0;
        n_checks++; if (pin_mask !== 32'hC000_0003) begin n_fail++; $display("FAIL wrap_mask got %h exp c0000003", pin_mask); end
        n_checks++; if ((pin_out & 32'hC000_0003) !== 32'hC000_0002) begin n_fail++; $display("FAIL wrap_pins got %h exp c0000002", pin_out & 32'hC000_0003); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy got %0b exp 0", busy); end
        tick();
        n_checks++; if ((pin_out & 32'hC000_0003) !== 32'hC000_0002 || pin_mask !== 32'h0) begin
            n_fail++; $display("FAIL wrap_hold got pins=%h mask=%h exp c0000002/0", pin_out & 32'hC000_0003, pin_mask); end
    endtask

    task automatic test_stall();
        int strobes = 0;
        int busy_cycles = 0;
        idle_inputs();
        exec_valid = 1; instr_stall = 1; delay = 5'd2; side_set = 5'b00001;
        sideset_enabled = 1; sideset_count = 3'd1; sideset_base = 5'd8;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (pin_mask != 0) strobes++;
            if (k == 0) begin
                n_checks++; if (pin_mask !== 32'h100) begin n_fail++; $display("FAIL stall_first got %h exp 100", pin_mask); end
            end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_nobusy k=%0d got %0b exp 0", k, busy); end
        end
        instr_stall = 0;
        tick();
        exec_valid = 0;
        if (pin_mask != 0) strobes++;
        if (busy) busy_cycles++;
        n_checks++; if (busy !== 1'b1 || delay_cnt !== 5'd2) begin n_fail++; $display("FAIL stall_release got busy=%0b cnt=%0d exp 1/2", busy, delay_cnt); end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (pin_mask != 0) strobes++;
            if (busy) busy_cycles++;
        end
        n_checks++; if (strobes !== 1) begin n_fail++; $display("FAIL stall_strobes got %0d exp 1", strobes); end
        n_checks++; if (busy_cycles !== 2) begin n_fail++; $display("FAIL stall_busy_len got %0d exp 2", busy_cycles); end
    endtask

    task automatic test_pindir();
        idle_inputs();
        exec_valid = 1; side_set = 5'b00011; sideset_enabled = 1;
        sideset_count = 3'd2; sideset_base = 5'd0; sideset_pindir = 1;
        tick();
        exec_valid = 0;
        n_checks++; if (dir_mask !== 32'h3) begin n_fail++; $display("FAIL pindir_mask got %h exp 3", dir_mask); end
        n_checks++; if (dir_out[1:0] !== 2'b11) begin n_fail++; $display("FAIL pindir_out got %b exp 11", dir_out[1:0]); end
        n_checks++; if (pin_mask !== 32'h0) begin n_fail++; $display("FAIL pindir_pinmask got %h exp 0", pin_mask); end
        tick();
    endtask

    task automatic test_en_mid_delay();
        int busy_cycles = 0;
        idle_inputs();
        exec_valid = 1; delay = 5'd31;
        tick();
        exec_valid = 0;
        if (busy) busy_cycles++;
        for (int k = 0; k < 60; k++) begin
            if (k == 10) en = 0;
            if (k == 15) en = 1;
            tick();
            if (busy) busy_cycles++;
        end
        n_checks++; if (busy_cycles !== 36) begin n_fail++; $display("FAIL en_extend got %0d exp 36", busy_cycles); end
    endtask

    task automatic test_restart();
        idle_inputs();
        exec_valid = 1; delay = 5'd10;
        tick();
        exec_valid = 0;
        tick(); tick();
        restart = 1; exec_valid = 1; sideset_enabled = 1; sideset_count = 3'd2; side_set = 5'b11;
        tick();
        restart = 0; exec_valid = 0;
        n_checks++; if (busy !== 1'b0 || delay_cnt !== 5'd0) begin n_fail++; $display("FAIL restart_clear got busy=%0b cnt=%0d exp 0/0", busy, delay_cnt); end
        n_checks++; if (pin_mask !== 32'h0) begin n_fail++; $display("FAIL restart_nostrobe got %h exp 0", pin_mask); end
    endtask

    task automatic test_issue_while_busy();
        idle_inputs();
        exec_valid = 1; delay = 5'd4; sideset_enabled = 1; sideset_count = 3'd1;
        sideset_base = 5'd12; side_set = 5'd1;
        tick();
        side_set = 5'd0; sideset_base = 5'd20; delay = 5'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (pin_mask !== 32'h0 || dir_mask !== 32'h0) begin n_fail++; $display("FAIL busy_ignore k=%0d got %h/%h exp 0/0", k, pin_mask, dir_mask); end
        end
        exec_valid = 0;
        n_checks++; if (delay_cnt !== 5'd1) begin n_fail++; $display("FAIL busy_noreload got %0d exp 1", delay_cnt); end
        tick(); tick();
    endtask

    task automatic test_no_sideset();
        idle_inputs();
        exec_valid = 1;
        for (int k = 0; k < 6; k++) begin
            sideset_enabled = (k % 2 == 0);
            sideset_count   = (k % 2 == 0) ? 3'd0 : 3'd3;
            side_set        = 5'(k + 5);
            tick();
            n_checks++; if (pin_mask !== 32'h0 || dir_mask !== 32'h0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL no_sideset k=%0d got mask=%h/%h busy=%0b exp 0/0/0", k, pin_mask, dir_mask, busy); end
        end
        exec_valid = 0;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        exec_valid = 1; delay = 5'd12;
        tick();
        exec_valid = 0;
        tick();
        #2 reset = 1;
        #1;
        n_checks++; if (busy !== 1'b0 || delay_cnt !== 5'd0) begin n_fail++; $display("FAIL async_reset got busy=%0b cnt=%0d exp 0/0", busy, delay_cnt); end
        #1 reset = 0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_release got %0b exp 0", busy); end
    endtask

    task automatic test_random();
        do_reset();
        m_cnt = 0; m_applied = 0;
        m_pin_out = '0; m_pin_mask = '0; m_dir_out = '0; m_dir_mask = '0;
        for (int c = 0; c < 600; c++) begin
            en              = ($urandom_range(0, 9) != 0);
            restart         = ($urandom_range(0, 24) == 0);
            exec_valid      = ($urandom_range(0, 2) != 0);
            instr_stall     = ($urandom_range(0, 3) == 0);
            delay           = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            side_set        = 5'($urandom);
            sideset_enabled = ($urandom_range(0, 4) != 0);
            sideset_count   = 3'($urandom);
            sideset_base    = 5'($urandom);
            sideset_pindir  = 1'($urandom);
            model_step();
            tick();
            n_checks++; if (busy !== (m_cnt != 0) || delay_cnt !== 5'(m_cnt)) begin
                n_fail++; $display("FAIL rand_delay c=%0d got busy=%0b cnt=%0d exp %0b/%0d", c, busy, delay_cnt, m_cnt != 0, m_cnt); end
            n_checks++; if (pin_mask !== m_pin_mask || pin_out !== m_pin_out) begin
                n_fail++; $display("FAIL rand_pins c=%0d got %h/%h exp %h/%h", c, pin_mask, pin_out, m_pin_mask, m_pin_out); end
            n_checks++; if (dir_mask !== m_dir_mask || dir_out !== m_dir_out) begin
                n_fail++; $display("FAIL rand_dirs c=%0d got %h/%h exp %h/%h", c, dir_mask, dir_out, m_dir_mask, m_dir_out); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_pindir();
        test_en_mid_delay();
        test_restart();
        test_issue_while_busy();
        test_no_sideset();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
